// File: rtl/axis_frame_mux_pkg.sv
// Shared types and helpers for the line-atomic N-channel stream mux.
// Holds the FSM state type, skid slice depth and select range check.
package axis_frame_mux_pkg;

    typedef enum logic {
        BOUNDARY = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    localparam int SLICE_DEPTH = 2;

    function automatic logic sel_valid(input int unsigned sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/axis_frame_mux_if.sv
// Line-framed stream bundle: payload plus start-of-frame / end-of-line markers.
// Master drives payload and valid, slave returns ready.
interface axis_frame_mux_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
    logic              valid;
    logic              ready;

    modport Master (output data, output sof, output eol, output valid, input ready);
    modport Slave  (input data, input sof, input eol, input valid, output ready);
endinterface

// File: rtl/axis_skid_slice.sv
// Two-entry registered stream slice: 1-cycle latency, full throughput.
// Input ready is a registered "not full", so downstream ready never reaches upstream combinationally.
module axis_skid_slice
    import axis_frame_mux_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_sof,
    input  logic              i_eol,
    output logic              o_rdy,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_sof,
    output logic              o_eol,
    input  logic              i_rdy
);

    logic [DATA_W-1:0] r_dat [SLICE_DEPTH];
    logic              r_sof [SLICE_DEPTH];
    logic              r_eol [SLICE_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_cnt;
    logic              r_not_full;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_cnt_nxt;

    assign o_rdy  = r_not_full;
    assign o_vld  = (r_cnt != 2'd0);
    assign o_dat  = r_dat[r_rd_ptr];
    assign o_sof  = r_sof[r_rd_ptr];
    assign o_eol  = r_eol[r_rd_ptr];

    assign w_push = i_vld && r_not_full;
    assign w_pop  = o_vld && i_rdy;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SLICE_DEPTH; i++) begin
                r_dat[i] <= '0;
                r_sof[i] <= 1'b0;
                r_eol[i] <= 1'b0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
            r_not_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_dat[r_wr_ptr] <= i_dat;
                r_sof[r_wr_ptr] <= i_sof;
                r_eol[r_wr_ptr] <= i_eol;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt      <= w_cnt_nxt;
            // Ready for next cycle is decided from the post-update occupancy.
            r_not_full <= (w_cnt_nxt < 2'(SLICE_DEPTH));
        end
    end

endmodule

// File: rtl/axis_frame_mux.sv
// N-channel line-atomic stream mux; source only switches between lines, output through a 2-entry skid slice.
// Latency 1 cycle; slave ready is registered. AXIS_FRAME_MUX_PROTOCOL_CHECK_EN adds err_o / err_cnt_o.
module axis_frame_mux
    import axis_frame_mux_pkg::*;
#(
    parameter int N_CH                 = 4,
    parameter int SEL_W                = $clog2(N_CH),
    parameter int DATA_W               = 16,
    parameter int SWITCH_ON_RESET_ONLY = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    axis_frame_mux_if.Slave         s_axis [N_CH],
    axis_frame_mux_if.Master        m_axis,
    input  logic [SEL_W-1:0]        select_i,
    output logic                    busy_o,
    output logic [SEL_W-1:0]        cur_sel_o
`ifdef AXIS_FRAME_MUX_PROTOCOL_CHECK_EN
    ,
    output logic                    err_o,
    output logic [7:0]              err_cnt_o
`endif
);

    state_e            r_state;
    logic [SEL_W-1:0]  r_lock_sel;
    logic [SEL_W-1:0]  r_cur_sel;
    logic              r_busy;
    logic              r_route_vld;

    logic [N_CH-1:0]   w_s_vld;
    logic [N_CH-1:0]   w_s_sof;
    logic [N_CH-1:0]   w_s_eol;
    logic [DATA_W-1:0] w_s_dat [N_CH];
    logic [N_CH-1:0]   w_grant;

    logic [SEL_W-1:0]  w_eff_sel;
    logic              w_route_vld;
    logic              w_route_ok;
    logic              w_sel_vld;
    logic              w_sel_sof;
    logic              w_sel_eol;
    logic [DATA_W-1:0] w_sel_dat;
    logic              w_slice_rdy;
    logic              w_acc;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_s_vld[g]     = s_axis[g].valid;
        assign w_s_sof[g]     = s_axis[g].sof;
        assign w_s_eol[g]     = s_axis[g].eol;
        assign w_s_dat[g]     = s_axis[g].data;
        assign s_axis[g].ready = w_grant[g];
    end

    // Static route mode waits one cycle after reset to capture its channel.
    assign w_route_vld = (SWITCH_ON_RESET_ONLY == 0) ? 1'b1 : r_route_vld;
    assign w_eff_sel   = ((SWITCH_ON_RESET_ONLY != 0) || (r_state == LOCKED)) ? r_lock_sel : select_i;
    assign w_route_ok  = w_route_vld && sel_valid(32'(w_eff_sel), N_CH);

    always_comb begin
        w_grant   = '0;
        w_sel_vld = 1'b0;
        w_sel_sof = 1'b0;
        w_sel_eol = 1'b0;
        w_sel_dat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_route_ok && (w_eff_sel == SEL_W'(i))) begin
                w_grant[i] = w_slice_rdy;
                w_sel_vld  = w_s_vld[i];
                w_sel_sof  = w_s_sof[i];
                w_sel_eol  = w_s_eol[i];
                w_sel_dat  = w_s_dat[i];
            end
        end
    end

    assign w_acc = w_sel_vld && w_slice_rdy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= BOUNDARY;
            r_lock_sel  <= '0;
            r_cur_sel   <= '0;
            r_busy      <= 1'b0;
            r_route_vld <= 1'b0;
        end else begin
            if ((SWITCH_ON_RESET_ONLY != 0) && !r_route_vld) begin
                r_lock_sel  <= select_i;
                r_route_vld <= 1'b1;
            end
            if (w_acc) begin
                r_cur_sel <= w_eff_sel;
                case (r_state)
                    BOUNDARY: begin
                        if (!w_sel_eol) begin
                            r_state    <= LOCKED;
                            r_busy     <= 1'b1;
                            r_lock_sel <= w_eff_sel;
                        end
                    end
                    LOCKED: begin
                        if (w_sel_eol) begin
                            r_state <= BOUNDARY;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= BOUNDARY;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o    = r_busy;
    assign cur_sel_o = r_cur_sel;

    axis_skid_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_vld   (w_route_ok && w_sel_vld),
        .i_dat   (w_sel_dat),
        .i_sof   (w_sel_sof),
        .i_eol   (w_sel_eol),
        .o_rdy   (w_slice_rdy),
        .o_vld   (m_axis.valid),
        .o_dat   (m_axis.data),
        .o_sof   (m_axis.sof),
        .o_eol   (m_axis.eol),
        .i_rdy   (m_axis.ready)
    );

`ifdef AXIS_FRAME_MUX_PROTOCOL_CHECK_EN
    logic [8:0] r_stall_cnt;
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       w_stall;
    logic       w_sof_err;
    logic       w_stall_err;

    assign w_stall     = (r_state == LOCKED) && !w_sel_vld;
    assign w_sof_err   = w_acc && w_sel_sof && (r_state == LOCKED);
    // Fires on the 256th consecutive idle cycle of a locked line, once per stall.
    assign w_stall_err = w_stall && (r_stall_cnt == 9'd255);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != 9'd256) begin
                r_stall_cnt <= r_stall_cnt + 9'd1;
            end
            r_err <= w_sof_err || w_stall_err;
            if ((w_sof_err || w_stall_err) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
`endif

endmodule
